cgol_decoder: RTL and testbench

//   Next-state rule for one Conway's Game of Life cell.
//   - Counts the live cells among the 8 neighbours (sides).
//   - Combines the count with the cell's own state (center) to decide whether the cell is live next generation.
//   - Used once per cell in the CGoL array.
//   - Provides a combinational result plus a registered copy for the array's state update.

---
 rtl/cgol_decoder_if.sv | 28 ++
 rtl/cgol_decoder.sv | 48 ++++
 tb/tb_cgol_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cgol_decoder_if.sv
// Per-cell neighbourhood bus: cell and neighbour states in, next-state results out.
// The decoder is the slave; the array (or bench) driving the states is the master.
interface cgol_decoder_if;
  logic       en;
  logic       center;
  logic [7:0] sides;
  logic       nexton;
  logic [3:0] count;
  logic       nexton_q;

  modport master (
    output en,
    output center,
    output sides,
    input  nexton,
    input  count,
    input  nexton_q
  );

  modport slave (
    input  en,
    input  center,
    input  sides,
    output nexton,
    output count,
    output nexton_q
  );
endinterface

// File: rtl/cgol_decoder.sv
// Game of Life next-state rule for one cell: combinational nexton/count, plus a registered
// copy nexton_q (1 cycle, loads when en=1). There is no backpressure; en only gates the register.
module cgol_decoder #(
  parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
  parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100
) (
  input  logic           ph1,
  input  logic           resetb,
  cgol_decoder_if.slave  bus
);

  logic [3:0] count_sum;
  logic       next_live;
  logic       state_d;
  logic       state_q;

  always_comb begin
    count_sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_sum = count_sum + {3'b000, bus.sides[i]};
    end
  end

  // count never exceeds 8, so the mask index is always in range.
  always_comb begin
    next_live = bus.center ? SURVIVE_MASK[count_sum] : BIRTH_MASK[count_sum];
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      state_d = next_live;
    end
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.count    = count_sum;
  assign bus.nexton   = next_live;
  assign bus.nexton_q = state_q;

endmodule

// File: tb/tb_cgol_decoder.sv
// Directed and exhaustive checks of the cell rule, count and the registered next state.
module tb_cgol_decoder;

  logic ph1;
  logic resetb;
  int   n_checks;
  int   n_fail;

  cgol_decoder_if bus_if ();

  cgol_decoder dut (
    .ph1    (ph1),
    .resetb (resetb),
    .bus    (bus_if)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       center;
    logic [7:0] sides;
    logic       exp_next;
  } vec_t;

  vec_t vecs [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{1'b1, 8'b0000_0000, 1'b0};
    vecs[1] = '{1'b1, 8'b0000_0011, 1'b1};
    vecs[2] = '{1'b1, 8'b0001_0101, 1'b1};
    vecs[3] = '{1'b1, 8'b0000_1111, 1'b0};
    vecs[4] = '{1'b0, 8'b1001_0010, 1'b1};
    vecs[5] = '{1'b0, 8'b0000_0011, 1'b0};
    vecs[6] = '{1'b0, 8'b1111_1111, 1'b0};

    resetb        = 1'b0;
    bus_if.en     = 1'b0;
    bus_if.center = 1'b0;
    bus_if.sides  = 8'h00;
    #1;
    check("reset_q", 32'(bus_if.nexton_q), 32'd0);

    // Combinational path with the register held in reset.
    for (int k = 0; k < 7; k++) begin
      @(negedge ph1);
      bus_if.center = vecs[k].center;
      bus_if.sides  = vecs[k].sides;
      #2;
      check($sformatf("dir_next%0d", k), 32'(bus_if.nexton), 32'(vecs[k].exp_next));
    end
    check("dir_count8", 32'(bus_if.count), 32'd8);

    for (int v = 0; v < 512; v++) begin
      int   cnt;
      logic exp_n;
      @(negedge ph1);
      bus_if.center = v[8];
      bus_if.sides  = v[7:0];
      cnt = 0;
      for (int b = 0; b < 8; b++) cnt += v[b];
      exp_n = v[8] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      #2;
      check($sformatf("ex_next_%0d", v), 32'(bus_if.nexton), 32'(exp_n));
      check($sformatf("ex_count_%0d", v), 32'(bus_if.count), 32'(cnt));
    end

    // Registered path.
    @(negedge ph1);
    resetb        = 1'b1;
    bus_if.en     = 1'b1;
    bus_if.center = 1'b0;
    bus_if.sides  = 8'h07;
    @(posedge ph1);
    #1;
    check("load_birth", 32'(bus_if.nexton_q), 32'd1);

    @(negedge ph1);
    bus_if.en = 1'b0;
    for (int e = 0; e < 3; e++) begin
      bus_if.center = 1'b1;
      bus_if.sides  = (e == 0) ? 8'h00 : ((e == 1) ? 8'h0F : 8'hFF);
      #1;
      check($sformatf("hold_next%0d", e), 32'(bus_if.nexton), 32'd0);
      @(posedge ph1);
      #1;
      check($sformatf("hold_q%0d", e), 32'(bus_if.nexton_q), 32'd1);
      @(negedge ph1);
    end

    bus_if.en     = 1'b1;
    bus_if.center = 1'b0;
    bus_if.sides  = 8'h07;
    #2;
    resetb = 1'b0;
    #1;
    check("midrst_q", 32'(bus_if.nexton_q), 32'd0);
    check("midrst_next", 32'(bus_if.nexton), 32'd1);
    bus_if.sides = 8'h00;
    #1;
    check("midrst_track", 32'(bus_if.nexton), 32'd0);
    bus_if.sides = 8'h07;
    @(posedge ph1);
    #1;
    check("rst_beats_clk", 32'(bus_if.nexton_q), 32'd0);

    @(negedge ph1);
    resetb = 1'b1;
    @(posedge ph1);
    #1;
    check("rel_load", 32'(bus_if.nexton_q), 32'd1);

    @(negedge ph1);
    bus_if.center = 1'b1;
    bus_if.sides  = 8'h00;
    @(posedge ph1);
    #1;
    check("load_death", 32'(bus_if.nexton_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
